// File: rtl/fmap_stream_reader.sv
// Serializes FilterNum feature maps as a raster word stream with row/map/last flags; FMAP_RELU_EN rectifies words.
// Latency: first word valid one cycle after start, then one word per cycle while out_ready is high.
// Backpressure: valid/ready; data and sideband hold until accepted, out_valid never drops without a transfer.
module fmap_stream_reader #(
    parameter int Oelements  = 28,
    parameter int FilterNum  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Fmaps [0:FilterNum-1][0:Oelements-1][0:Oelements-1],
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6:0]            out_filter,
    output logic                  out_eol,
    output logic                  out_eom,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (Oelements > 1) ? $clog2(Oelements) : 1;
    localparam int FW = (FilterNum > 1) ? $clog2(FilterNum) : 1;
    localparam logic [CW-1:0] CMAX = CW'(Oelements - 1);
    localparam logic [6:0]    FMAX = 7'(FilterNum - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   row_q, row_d;
    logic [6:0]      fil_q, fil_d;

    logic                  at_eol, at_eom, at_last;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] word;

    function automatic logic [DATA_WIDTH-1:0] rectify(input logic [DATA_WIDTH-1:0] w);
`ifdef FMAP_RELU_EN
        return w[DATA_WIDTH-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Counters always name the element to be loaded next; they park on the final element.
    always_comb begin
        at_eol  = (col_q == CMAX);
        at_eom  = at_eol && (row_q == CMAX);
        at_last = at_eom && (fil_q == FMAX);
        word    = rectify(Fmaps[fil_q[FW-1:0]][row_q][col_q]);
        col_d   = col_q;
        row_d   = row_q;
        fil_d   = fil_q;
        if (!at_last) begin
            if (at_eol) begin
                col_d = '0;
                if (row_q == CMAX) begin
                    row_d = '0;
                    fil_d = fil_q + 7'd1;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        load_en = 1'b0;
        if (state_q == IDLE)
            load_en = start;
        else if (state_q == STREAM)
            load_en = out_valid && out_ready && !out_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            fil_q      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_filter <= '0;
            out_eol    <= 1'b0;
            out_eom    <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= STREAM;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready && out_last) begin
                        state_q   <= DONE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    col_q   <= '0;
                    row_q   <= '0;
                    fil_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase

            if (load_en) begin
                out_data   <= word;
                out_filter <= fil_q;
                out_eol    <= at_eol;
                out_eom    <= at_eom;
                out_last   <= at_last;
                col_q      <= col_d;
                row_q      <= row_d;
                fil_q      <= fil_d;
            end
        end
    end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: full stream, random backpressure, ignored starts, mid-stream reset.
module tb_fmap_stream_reader;

    localparam int OE = 28;
    localparam int FN = 6;
    localparam int DW = 32;
    localparam int NW = FN * OE * OE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] fmaps [0:FN-1][0:OE-1][0:OE-1];
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [6:0]    out_filter;
    logic          out_eol, out_eom, out_last, busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    fmap_stream_reader #(.Oelements(OE), .FilterNum(FN), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .Fmaps      (fmaps),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_filter (out_filter),
        .out_eol    (out_eol),
        .out_eom    (out_eom),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expw(input int k);
        int f, r, c;
        f = k / (OE * OE);
        r = (k / OE) % OE;
        c = k % OE;
        if (f == 2 && r == 3 && c == 4) begin
`ifdef FMAP_RELU_EN
            return 32'h0;
`else
            return 32'hFFFF_FFF6;
`endif
        end
        return 32'(f * 1000 + r * 28 + c);
    endfunction

    task automatic chk_word(input int k);
        int f, r, c;
        f = k / (OE * OE);
        r = (k / OE) % OE;
        c = k % OE;
        chk($sformatf("valid[%0d]", k),  {31'd0, out_valid}, 32'd1);
        chk($sformatf("data[%0d]", k),   out_data, expw(k));
        chk($sformatf("filter[%0d]", k), {25'd0, out_filter}, 32'(f));
        chk($sformatf("eol[%0d]", k),    {31'd0, out_eol}, {31'd0, c == OE - 1});
        chk($sformatf("eom[%0d]", k),    {31'd0, out_eom}, {31'd0, (c == OE - 1) && (r == OE - 1)});
        chk($sformatf("last[%0d]", k),   {31'd0, out_last}, {31'd0, k == NW - 1});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},  {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"},   out_data, 32'd0);
        chk({tag, "_filter"}, {25'd0, out_filter}, 32'd0);
        chk({tag, "_flags"},  {29'd0, out_eol, out_eom, out_last}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
        chk({tag, "_done"},   {31'd0, done}, 32'd0);
    endtask

    initial begin
        int k;
        int busy_cnt;
        int early_done;
        int ndone;
        logic hold;
        logic sent;
        logic [31:0] pd;
        logic [9:0]  pf;

        for (int f = 0; f < FN; f++)
            for (int r = 0; r < OE; r++)
                for (int c = 0; c < OE; c++)
                    fmaps[f][r][c] = 32'(f * 1000 + r * 28 + c);
        fmaps[2][3][4] = 32'hFFFF_FFF6;

        // Reset state
        #2 rst_n = 1'b0;
        #10 chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); chk_zero("idle");

        // Run 1: full stream with out_ready held high
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_data", out_data, 32'd0);
        chk("first_busy", {31'd0, busy}, 32'd1);
        k = 0; busy_cnt = 0; early_done = 0;
        for (int cyc = 0; cyc < NW + 50 && k < NW; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) early_done++;
            if (out_valid) begin
                chk_word(k);
                k++;
            end
        end
        chk("run1_count", 32'(k), 32'(NW));
        chk("run1_early_done", 32'(early_done), 32'd0);
        @(negedge clk);
        chk("run1_done", {31'd0, done}, 32'd1);
        chk("run1_busy_off", {31'd0, busy}, 32'd0);
        chk("run1_valid_off", {31'd0, out_valid}, 32'd0);
        chk("run1_busy_cycles", 32'(busy_cnt), 32'(NW));
        @(negedge clk);
        chk("run1_done_pulse", {31'd0, done}, 32'd0);

        // Run 2: random backpressure, extra start at word 100
        out_ready = 1'b0;
        start = 1'b1;
        k = 0; ndone = 0; hold = 1'b0; sent = 1'b0; pd = '0; pf = '0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                break;
            end
            if (out_valid) begin
                if (hold) begin
                    chk($sformatf("hold_data[%0d]", k), out_data, pd);
                    chk($sformatf("hold_flags[%0d]", k),
                        {22'd0, out_filter, out_eol, out_eom, out_last}, {22'd0, pf});
                end
                chk_word(k);
                out_ready = 1'($urandom_range(0, 1));
                hold = ~out_ready;
                pd = out_data;
                pf = {out_filter, out_eol, out_eom, out_last};
                if (out_ready) k++;
                if (k == 100 && !sent) begin
                    start = 1'b1;
                    sent = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                hold = 1'b0;
            end
        end
        chk("run2_count", 32'(k), 32'(NW));
        chk("run2_extra_start_sent", {31'd0, sent}, 32'd1);

        // start coinciding with DONE must be ignored
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (done) ndone++;
        chk("done_start_valid", {31'd0, out_valid}, 32'd0);
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        chk("run2_ndone", 32'(ndone), 32'd1);

        // Run 3: start from IDLE on the next cycle, reset mid-stream
        out_ready = 1'b1;
        start = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 3000 && k < 2000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                chk_word(k);
                k++;
            end
        end
        chk("run3_count", 32'(k), 32'd2000);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        @(negedge clk);
        chk_zero("midreset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid) begin
                chk_word(k);
                k++;
            end
        end
        chk("restart_count", 32'(k), 32'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fmap_stream_reader.md
Name: fmap_stream_reader

Overview:
- Reads the multi-filter convolution result array (FilterNum x Oelements x Oelements words) and serializes it as a valid/ready word stream for downstream pooling, DMA or debug capture.
- A single `start` pulse launches one complete read-out:
  - raster order within a map: column fastest, then row;
  - maps in order, filter 0 first.
- Sideband flags mark row ends, map ends and the final word.
- `busy` and `done` let the sequencer gate the convolution stage until the read-out completes.

Parameters:
- Oelements, 28, feature-map side length (map is Oelements x Oelements).
- FilterNum, 6, number of feature maps; max 128.
- DATA_WIDTH, 32, word width; two's-complement.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begin read-out. Ignored while busy=1.
- Fmaps  input  DATA_WIDTH x [FilterNum][Oelements][Oelements]  feature maps. Must hold stable while busy=1.
- out_data  output  DATA_WIDTH  current word.
- out_valid  output  1  out_data/sideband are valid.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- out_filter  output  7  filter index of the current word.
- out_eol  output  1  current word is the last column of a row.
- out_eom  output  1  current word is the last word of a map.
- out_last  output  1  current word is the last word of the whole read-out.
- busy  output  1  read-out in progress.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; counters col/row/fil=0.
  - out_valid=0, out_data=0, out_filter=0, out_eol=0, out_eom=0, out_last=0, busy=0, done=0.
- Counter widths:
  - col/row: $clog2(Oelements).
  - fil: 7 bits.
- States:
  - IDLE:
    - start=1 → STREAM. On the same edge: out_data<=Fmaps[0][0][0], out_valid<=1, busy<=1, counters point to the next element.
    - Latency: first word is valid the cycle after start.
  - STREAM:
    - Output registers load the next element only on a transfer (out_valid && out_ready).
    - Without a transfer, out_data and all sideband outputs hold. out_valid never drops without a transfer.
    - Transfer of a word with out_last=1 → DONE; out_valid<=0.
  - DONE: one cycle; done=1, busy=0 → IDLE.
- Counter advance:
  - col increments; at col=Oelements-1, col wraps to 0 and row increments.
  - At row=Oelements-1 with a column wrap, row wraps to 0 and fil increments.
  - No counter advances past the final element.
- Sideband values per word at (f,r,c):
  - out_eol = (c==Oelements-1).
  - out_eom = out_eol && (r==Oelements-1).
  - out_last = out_eom && (f==FilterNum-1).
  - out_filter = f.
- Throughput: one word per cycle while out_ready=1. Total transfers = FilterNum*Oelements*Oelements (4704 at defaults).
- Boundary conditions:
  - start while busy or in DONE: ignored, no restart.
  - start in the same cycle as DONE: ignored. A new start is accepted from IDLE on the next cycle.
  - out_ready=1 permanently: busy stays high exactly 4704 cycles; done follows on the next cycle.
  - rst_n asserted mid-stream: immediate return to reset values; the partial stream is abandoned; no done pulse.
  - Oelements=1: every word has out_eol=out_eom=1.

Optional Feature:
- Macro FMAP_RELU_EN.
- Defined:
  - Each word is rectified before loading into out_data: if bit DATA_WIDTH-1 is 1, out_data<=0; otherwise unchanged.
  - Sideband and timing are identical to the macro-undefined case.
- Undefined: raw words are passed unmodified.

Test Plan:
- Fmaps[f][r][c]=f*1000+r*28+c; start pulse, out_ready=1 → 4704 words in exact raster order; first word 0 valid 1 cycle after start; last word 5783 with out_last=1; done one cycle later.
- Flags on the same stream: out_eol every 28th word; out_eom at words 784, 1568, … 4704; out_filter increments 0..5 after each out_eom.
- out_ready random toggling ~50% → no word lost or duplicated; out_data and flags stable while out_valid=1 and out_ready=0.
- Second start pulse issued at word 100 → ignored; stream continues unchanged; exactly one done.
- rst_n low at word 2000 → all outputs 0 immediately; next start restarts at Fmaps[0][0][0].
- FMAP_RELU_EN defined, Fmaps[2][3][4]=32'hFFFF_FFF6 (-10) → that word reads 0; word holding 32'h0000_0007 reads 7. Undefined → word reads 32'hFFFF_FFF6.
